// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types and constants for the serial subtractor.
package arith_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } sub_state_t;

   localparam logic SUB_CARRY_SEED = 1'b1;
   localparam int   DEFAULT_WIDTH  = 8;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full-adder slice; fed with a and ~b it forms one subtract bit.
module serial_sub_cell (
   input  logic a_bit,
   input  logic nb_bit,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a_bit ^ nb_bit ^ cin;
   assign cout = (a_bit & nb_bit) | (a_bit & cin) | (nb_bit & cin);

endmodule

// File: rtl/serial_subtractor_8.sv
// Bit-serial a - b, LSB first, one full-adder cell reused over WIDTH cycles.
// Optional signed-overflow output ovf when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor_8
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_nxt;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             s, cout;
   logic             accept, last;

   serial_sub_cell u_cell (
      .a_bit  (a_sr[0]),
      .nb_bit (b_sr[0]),
      .cin    (carry),
      .s      (s),
      .cout   (cout)
   );

   // New sum bit enters at the MSB so after WIDTH shifts R holds the result.
   assign r_nxt = {s, r_sr[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt == CNT_LAST) begin
               last    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sr  <= a;
            b_sr  <= ~b;
            r_sr  <= '0;
            carry <= SUB_CARRY_SEED;
            cnt   <= '0;
            busy  <= 1'b1;
         end else if (state_q == BUSY) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_nxt;
            carry <= cout;
            cnt   <= last ? '0 : cnt + CNT_W'(1);
            if (last) begin
               diff   <= r_nxt;
               borrow <= ~cout;
               done   <= 1'b1;
               busy   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
               // carry still holds the carry into the MSB on the final bit
               ovf    <= carry ^ cout;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor_8.sv
// Scoreboard bench for serial_subtractor_8; define SERIAL_SUB_OVF_EN to cover ovf.
module tb_serial_subtractor_8;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, borrow;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor_8 #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         ov;
      int           k;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   last_done = -1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard side: every done pulse must match the oldest outstanding op.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("diff", diff, e.d);
            chk("borrow", borrow, e.br);
            chk("latency", cyc - e.k, W);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", ovf, e.ov);
`endif
            if (last_done >= 0) chk("spacing", (cyc - last_done) >= 9, 1);
            last_done = cyc;
         end
      end
   end

   // Waits for idle, then drives start for one cycle and queues the expectation.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, output logic was_done);
      exp_t e;
      logic [W-1:0] d;
      int n;
      n = 0;
      was_done = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 50);
      if (busy) begin
         chk("idle_timeout", 1, 0);
         return;
      end
      was_done = done;
      d    = av - bv;
      e.d  = d;
      e.br = (av < bv);
      e.ov = (av[W-1] != bv[W-1]) && (d[W-1] != av[W-1]);
      e.k  = cyc + 1;
      q.push_back(e);
      start = 1'b1;
      a = av;
      b = bv;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
   endtask

   logic wd;

   initial begin
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      @(negedge clk);
      rst = 1'b0;

      do_op(8'h50, 8'h20, wd);
      chk("busy_after_start", busy, 1);
      drain();
      do_op(8'h20, 8'h50, wd); drain();
      do_op(8'h00, 8'h01, wd); drain();
      do_op(8'hFF, 8'hFF, wd); drain();
      do_op(8'h80, 8'h01, wd); drain();
      do_op(8'h05, 8'h03, wd); drain();

      // start during BUSY is ignored; a/b wiggle has no effect
      do_op(8'h10, 8'h01, wd);
      repeat (2) @(negedge clk);
      start = 1'b1; a = 8'h99; b = 8'h11;
      @(negedge clk);
      start = 1'b0; a = 8'h00; b = 8'h00;
      do_op(8'h99, 8'h11, wd);
      chk("start_in_done", wd, 1);
      drain();

      // asynchronous reset mid-operation
      do_op(8'h40, 8'h10, wd);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_diff", diff, 0);
      chk("arst_borrow", borrow, 0);
      q.delete();
      last_done = -1;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      do_op(8'h40, 8'h10, wd); drain();

      for (int i = 0; i < 1000; i++)
         do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), wd);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
